mem_dma: RTL and testbench

//  Block-transfer engine mastering the data_memory ports: copy (memmove semantics) or fill.

---
 rtl/dma_pkg.sv | 11 +
 rtl/mem_dma_if.sv | 29 ++
 rtl/dma_addr_gen.sv | 29 ++
 rtl/mem_dma.sv | 127 ++++++++++++
 tb/tb_mem_dma.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared types for the block-transfer engine: FSM states, transfer mode, pointer direction.
package dma_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} dma_state_t;
  typedef enum logic {COPY = 1'b0, FILL = 1'b1} dma_mode_t;

  localparam logic ASC  = 1'b0;
  localparam logic DESC = 1'b1;
endpackage

// File: rtl/mem_dma_if.sv
// Control and memory-port bundle of mem_dma. master = the DMA engine, slave = CPU/memory side.
interface mem_dma_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] length;
  logic [DATA_W-1:0] fill_value;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_read_address;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_write_address;
  logic [DATA_W-1:0] mem_data_in;

  modport master (
    input  start, mode, src_addr, dst_addr, length, fill_value, abort, mem_data_out,
    output busy, done, mem_read_address, mem_write, mem_write_address, mem_data_in
  );
  modport slave (
    output start, mode, src_addr, dst_addr, length, fill_value, abort, mem_data_out,
    input  busy, done, mem_read_address, mem_write, mem_write_address, mem_data_in
  );
endinterface

// File: rtl/dma_addr_gen.sv
// Loadable up/down address pointer; wraps silently at the ends of the address space.
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] base,
  input  logic         step,
  input  logic         dir,
  output logic [W-1:0] ptr
);
  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load)      ptr_d = base;
    else if (step) ptr_d = (dir == DESC) ? ptr_q - W'(1) : ptr_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/mem_dma.sv
// Block-transfer engine: memmove-style COPY through a one-byte hold register, or FILL,
// one byte per cycle on the data_memory read/write ports.
module mem_dma
  import dma_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic       clk,
  input logic       reset,
  mem_dma_if.master bus
);
  dma_state_t        state_q, state_d;
  dma_mode_t         mode_q, mode_d;
  logic              dir_q, dir_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              done_q, done_d;

  logic              rd_load, rd_step, wr_load, wr_step, wslot;
  logic [ADDR_W-1:0] rd_base, wr_base, rd_ptr, wr_ptr;
  logic              start_desc;

  assign start_desc = (dma_mode_t'(bus.mode) == COPY) && (bus.dst_addr > bus.src_addr);

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    dir_d        = dir_q;
    rem_d        = rem_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    fill_d       = fill_q;
    done_d       = 1'b0;
    rd_load      = 1'b0;
    rd_step      = 1'b0;
    wr_load      = 1'b0;
    wr_step      = 1'b0;
    wslot        = 1'b0;
    rd_base      = start_desc ? bus.src_addr + bus.length - ADDR_W'(1) : bus.src_addr;
    wr_base      = start_desc ? bus.dst_addr + bus.length - ADDR_W'(1) : bus.dst_addr;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d      = RUN;
        mode_d       = dma_mode_t'(bus.mode);
        dir_d        = start_desc ? DESC : ASC;
        rem_d        = {bus.length == '0, bus.length};
        fill_d       = bus.fill_value;
        hold_valid_d = 1'b0;
        // FILL leaves the read pointer untouched so the read port stays quiet
        rd_load      = (dma_mode_t'(bus.mode) == COPY);
        wr_load      = 1'b1;
      end
      RUN: begin
        rem_d = rem_q - (ADDR_W+1)'(1);
        if (mode_q == COPY) begin
          rd_step      = 1'b1;
          hold_d       = bus.mem_data_out;
          hold_valid_d = 1'b1;
          wslot        = hold_valid_q;
          wr_step      = hold_valid_q;
          if (rem_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end else begin
          wslot   = 1'b1;
          wr_step = 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      DRAIN: begin
        wslot        = hold_valid_q;
        state_d      = IDLE;
        hold_valid_d = 1'b0;
        done_d       = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && bus.abort) begin
      state_d      = IDLE;
      hold_valid_d = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mode_q       <= COPY;
      dir_q        <= ASC;
      rem_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      fill_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      dir_q        <= dir_d;
      rem_q        <= rem_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      fill_q       <= fill_d;
      done_q       <= done_d;
    end
  end

  dma_addr_gen #(.W(ADDR_W)) u_rd (
    .clk(clk), .reset(reset), .load(rd_load), .base(rd_base),
    .step(rd_step), .dir(dir_d), .ptr(rd_ptr)
  );
  dma_addr_gen #(.W(ADDR_W)) u_wr (
    .clk(clk), .reset(reset), .load(wr_load), .base(wr_base),
    .step(wr_step), .dir(dir_d), .ptr(wr_ptr)
  );

  // Writes commit at the edge, so a same-cycle read still sees the old byte
  assign bus.mem_write         = wslot & ~bus.abort;
  assign bus.mem_write_address = wr_ptr;
  assign bus.mem_data_in       = (mode_q == FILL) ? fill_q : hold_q;
  assign bus.mem_read_address  = rd_ptr;
  assign bus.busy              = (state_q != IDLE);
  assign bus.done              = done_q;
endmodule

// File: tb/tb_mem_dma.sv
// Directed plus random transfers against a data_memory model and a memmove/fill reference.
module tb_mem_dma;
  import dma_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_dma_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  mem_dma #(.ADDR_W(8), .DATA_W(8)) dut (.clk(clk), .reset(reset), .bus(bus.master));

  logic [7:0] mem [256];
  logic [7:0] ref_m [256];
  logic       pl_we = 1'b0;
  logic [7:0] pl_addr, pl_data;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (bus.mem_write) mem[bus.mem_write_address] <= bus.mem_data_in;
  end
  assign bus.mem_data_out = mem[bus.mem_read_address];

  int busy_cnt, done_cnt, rd_moves;
  logic [7:0] last_rd;
  logic [7:0] wa_q[$], wd_q[$];
  always @(negedge clk) begin
    if (bus.busy) busy_cnt++;
    if (bus.done) done_cnt++;
    if (bus.mem_write) begin
      wa_q.push_back(bus.mem_write_address);
      wd_q.push_back(bus.mem_data_in);
    end
    if (bus.busy && bus.mem_read_address != last_rd) rd_moves++;
    last_rd = bus.mem_read_address;
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_we = 1'b0;
    ref_m[a] = d;
  endtask

  // ab: busy-cycle index (from 0) carrying abort; rs: busy-cycle index where reset drops
  task automatic xfer(input string tag, input logic m, input logic [7:0] s, input logic [7:0] d,
                      input int L, input logic [7:0] fv, input int ab, input int rs, input bit stress);
    logic [7:0] snap [256];
    logic [7:0] ea[$], ed[$];
    logic [7:0] a, v, sa;
    int n_exp, busy_exp, cyc, bad, off;
    bit desc, cut;
    snap = ref_m;
    busy_cnt = 0; done_cnt = 0; rd_moves = 0;
    wa_q.delete(); wd_q.delete();
    bus.start = 1'b1; bus.mode = m; bus.src_addr = s; bus.dst_addr = d;
    bus.length = 8'(L); bus.fill_value = fv; bus.abort = stress;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.src_addr = ~s; bus.dst_addr = ~d; bus.length = 8'(L + 3); bus.fill_value = ~fv; bus.mode = ~m;
    cyc = 0;
    while (bus.busy && cyc < 400) begin
      if (cyc == rs) begin
        reset = 1'b0;
        #1;
        check({tag, "_rst_busy"}, 32'(bus.busy), 0);
        check({tag, "_rst_wr"}, 32'(bus.mem_write), 0);
        check({tag, "_rst_done"}, 32'(bus.done), 0);
        tick();
        reset = 1'b1;
      end else begin
        if (cyc == ab) bus.abort = 1'b1;
        if (stress && cyc == 1) bus.start = 1'b1;
        tick();
        bus.abort = 1'b0; bus.start = 1'b0;
      end
      cyc++;
    end
    check({tag, "_terminates"}, 32'(cyc < 400), 1);
    tick();

    desc = (m == 1'b0) && (d > s);
    cut = 1'b0;
    n_exp = L;
    busy_exp = (m == 1'b0) ? L + 1 : L;
    if (rs >= 0) begin
      cut = 1'b1; busy_exp = rs;
      n_exp = (m == 1'b0) ? ((rs > 0) ? rs - 1 : 0) : rs;
    end else if (ab >= 0 && ab < busy_exp) begin
      cut = 1'b1; busy_exp = ab + 1;
      n_exp = (m == 1'b0) ? ((ab > 0) ? ab - 1 : 0) : ab;
    end
    for (int k = 0; k < n_exp; k++) begin
      off = desc ? L - 1 - k : k;
      a = d + 8'(off);
      sa = s + 8'(off);
      v = m ? fv : snap[sa];
      ea.push_back(a); ed.push_back(v);
      ref_m[a] = v;
    end

    check({tag, "_writes"}, 32'(wa_q.size()), 32'(n_exp));
    check({tag, "_busy"}, 32'(busy_cnt), 32'(busy_exp));
    check({tag, "_done"}, 32'(done_cnt), cut ? 0 : 1);
    bad = 0;
    for (int k = 0; k < n_exp && k < wa_q.size(); k++)
      if (wa_q[k] !== ea[k] || wd_q[k] !== ed[k]) bad++;
    check({tag, "_wr_seq"}, 32'(bad), 0);
    if (m) check({tag, "_no_reads"}, 32'(rd_moves), 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_m[i]) bad++;
    check({tag, "_mem"}, 32'(bad), 0);
  endtask

  initial begin
    logic [7:0] s, d;
    int L;
    bus.start = 1'b0; bus.mode = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
    bus.length = '0; bus.fill_value = '0; bus.abort = 1'b0;
    pl_addr = '0; pl_data = '0;
    tick(); tick();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_wr", 32'(bus.mem_write), 0);
    check("rst_raddr", 32'(bus.mem_read_address), 0);
    check("rst_waddr", 32'(bus.mem_write_address), 0);
    check("rst_wdata", 32'(bus.mem_data_in), 0);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));

    for (int i = 0; i < 4; i++) preload(8'(8'h10 + i), 8'(8'hA1 + i));
    xfer("copy_basic", 1'b0, 8'h10, 8'h40, 4, 8'h00, -1, -1, 1'b0);

    for (int i = 0; i < 4; i++) preload(8'(8'h20 + i), 8'(i + 1));
    xfer("copy_overlap", 1'b0, 8'h20, 8'h22, 4, 8'h00, -1, -1, 1'b0);
    check("overlap_first_waddr", 32'(wa_q.size() > 0 ? wa_q[0] : 8'h00), 32'h25);
    check("overlap_byte0", 32'(mem[8'h22]), 1);
    check("overlap_byte3", 32'(mem[8'h25]), 4);

    xfer("fill_wrap", 1'b1, 8'h00, 8'hFE, 4, 8'h5A, -1, -1, 1'b0);
    check("fill_ff", 32'(mem[8'hFF]), 32'h5A);

    xfer("copy_len0", 1'b0, 8'h00, 8'h00, 256, 8'h00, -1, -1, 1'b0);
    xfer("copy_abort", 1'b0, 8'h30, 8'h80, 8, 8'h00, 3, -1, 1'b0);
    xfer("after_abort", 1'b0, 8'h50, 8'h90, 5, 8'h00, -1, -1, 1'b0);
    xfer("fill_abort", 1'b1, 8'h00, 8'hA0, 6, 8'h33, 2, -1, 1'b0);
    xfer("copy_reset", 1'b0, 8'h60, 8'hB0, 8, 8'h00, -1, 3, 1'b0);
    xfer("after_reset", 1'b0, 8'h60, 8'hC0, 8, 8'h00, -1, -1, 1'b0);
    xfer("start_busy", 1'b0, 8'h70, 8'h68, 6, 8'h00, -1, -1, 1'b1);

    for (int r = 0; r < 8; r++) begin
      L = $urandom_range(1, 48);
      s = 8'($urandom_range(0, 255 - L));
      d = 8'($urandom_range(0, 255 - L));
      xfer($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), s, d, L, 8'($urandom), -1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
